// File: rtl/tdc_readout_pkg.sv
// Shared constants and serialiser state type for the TDC readout path.
// Defining TDC_SEQ_TAG_EN adds the sequence-tag state.
package tdc_readout_pkg;

  localparam int unsigned DIG_OUT      = 12;
  localparam logic [7:0]  TDC_HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    RO_IDLE = 2'd0,
    RO_HDR  = 2'd1,
`ifdef TDC_SEQ_TAG_EN
    RO_TAG  = 2'd2,
`endif
    RO_DATA = 2'd3
  } ro_state_e;

endpackage

// File: rtl/tdc_readout_sync_fifo.sv
// Single-clock FIFO with registered count and registered read data
// (dout is valid the cycle after pop). Caller guarantees no push when full.
module tdc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   irst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // When full, a same-cycle push and pop share a slot: dout captures the old entry first.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tdc_readout.sv
// Captures merged TDC words into a FIFO and serialises them as framed bytes
// (header, optional sequence tag under TDC_SEQ_TAG_EN, data MSB first).
module tdc_readout
  import tdc_readout_pkg::*;
#(
  parameter int unsigned W     = DIG_OUT,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   irst_n,
  input  logic [W-1:0]           meas_in,
  input  logic                   meas_vld,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  output logic                   ovf,
  output logic [7:0]             drop_cnt
);
  localparam int unsigned NB = (W + 7) / 8;
  localparam int unsigned SW = NB * 8;
  localparam int unsigned IW = $clog2(NB + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef TDC_SEQ_TAG_EN
  localparam int unsigned FW = W + 8;
  localparam ro_state_e AFTER_HDR = RO_TAG;
  logic [7:0] seq_cnt;
  logic [7:0] tag_q;
`else
  localparam int unsigned FW = W;
  localparam ro_state_e AFTER_HDR = RO_DATA;
`endif

  ro_state_e     state;
  ro_state_e     state_nx;
  logic          pop;
  logic          accept;
  logic          load_q;
  logic [SW-1:0] shreg;
  logic [IW-1:0] byte_idx;
  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;

  assign accept = meas_vld && ((fifo_cnt < FULL) || pop);
`ifdef TDC_SEQ_TAG_EN
  assign fifo_din = {seq_cnt, meas_in};
`else
  assign fifo_din = meas_in;
`endif

  tdc_sync_fifo #(
    .WIDTH(FW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .irst_n(irst_n),
    .push  (accept),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_cnt)
  );

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) state <= RO_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b1;
    tx_data  = TDC_HDR_BYTE;
    pop      = 1'b0;
    case (state)
      RO_IDLE: begin
        tx_valid = 1'b0;
        tx_data  = '0;
        if (fifo_cnt != '0) begin
          pop      = 1'b1;
          state_nx = RO_HDR;
        end
      end
      RO_HDR: if (tx_ready) state_nx = AFTER_HDR;
`ifdef TDC_SEQ_TAG_EN
      RO_TAG: begin
        tx_data = tag_q;
        if (tx_ready) state_nx = RO_DATA;
      end
`endif
      RO_DATA: begin
        tx_data = shreg[SW-1 -: 8];
        if (tx_ready && byte_idx == '0) begin
          if (fifo_cnt != '0) begin
            pop      = 1'b1;
            state_nx = RO_HDR;
          end else begin
            state_nx = RO_IDLE;
          end
        end
      end
      default: state_nx = RO_IDLE;
    endcase
  end

  // FIFO read data lands one cycle after pop, always during HDR, so the load never meets a shift.
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      load_q   <= 1'b0;
      shreg    <= '0;
      byte_idx <= '0;
`ifdef TDC_SEQ_TAG_EN
      tag_q    <= '0;
`endif
    end else begin
      load_q <= pop;
      if (load_q) begin
        shreg    <= SW'(fifo_dout[W-1:0]);
        byte_idx <= IW'(NB - 1);
`ifdef TDC_SEQ_TAG_EN
        tag_q    <= fifo_dout[FW-1:W];
`endif
      end else if (state == RO_DATA && tx_ready) begin
        shreg    <= shreg << 8;
        byte_idx <= byte_idx - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      ovf      <= 1'b0;
      drop_cnt <= '0;
`ifdef TDC_SEQ_TAG_EN
      seq_cnt  <= '0;
`endif
    end else begin
      if (meas_vld && !accept) begin
        ovf <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
      end
`ifdef TDC_SEQ_TAG_EN
      if (accept) seq_cnt <= seq_cnt + 1'b1;
`endif
    end
  end

endmodule
